seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_pkg.sv | 40 ++++
 rtl/seq_alu_step.sv | 92 +++++++++
 rtl/seq_alu.sv | 175 +++++++++++++++++
 tb/tb_seq_alu.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM states and flag bit positions for the sequential ALU.
package seq_alu_pkg;

  localparam logic [3:0] OP_PASS_A = 4'b0000;
  localparam logic [3:0] OP_PASS_B = 4'b0001;
  localparam logic [3:0] OP_NOT_A  = 4'b0010;
  localparam logic [3:0] OP_NOT_B  = 4'b0011;
  localparam logic [3:0] OP_ADD    = 4'b0100;
  localparam logic [3:0] OP_ADC    = 4'b0101;
  localparam logic [3:0] OP_SUB    = 4'b0110;
  localparam logic [3:0] OP_AND    = 4'b0111;
  localparam logic [3:0] OP_OR     = 4'b1000;
  localparam logic [3:0] OP_XOR    = 4'b1001;
  localparam logic [3:0] OP_NAND   = 4'b1010;
  localparam logic [3:0] OP_LSL    = 4'b1011;
  localparam logic [3:0] OP_LSR    = 4'b1100;
  localparam logic [3:0] OP_ASR    = 4'b1101;
  localparam logic [3:0] OP_CSL    = 4'b1110;
  localparam logic [3:0] OP_CSR    = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

  function automatic logic is_shift_op(input logic [3:0] op);
    return op >= OP_LSL;
  endfunction

  function automatic logic is_arith_op(input logic [3:0] op);
    return op inside {OP_ADD, OP_ADC, OP_SUB};
  endfunction

endpackage

// File: rtl/seq_alu_step.sv
// One combinational ALU operation or one single-bit shift step at full or half width.
module seq_alu_step
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic             half,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             ovf
);

  localparam int H = WIDTH / 2;

  logic [WIDTH-1:0] add_b;
  logic             add_ci;
  logic [WIDTH:0]   sum;
  logic             sa, sb, sr;
  logic [H-1:0]     lo, sh_lo;
  logic [WIDTH-1:0] sh_full;
  logic             out_lo, out_full;

  always_comb begin
    add_b  = (op == OP_SUB) ? ~b : b;
    add_ci = 1'b0;
    if (op == OP_ADC) add_ci = cin;
    if (op == OP_SUB) add_ci = 1'b1;
    sum = {1'b0, a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_ci};
    sa  = half ? a[H-1]     : a[WIDTH-1];
    sb  = half ? add_b[H-1] : add_b[WIDTH-1];
    sr  = half ? sum[H-1]   : sum[WIDTH-1];
  end

  // Half-width shifts act on the low half only; the result is re-extended.
  always_comb begin
    lo       = a[H-1:0];
    sh_full  = {a[WIDTH-2:0], 1'b0};
    out_full = a[WIDTH-1];
    sh_lo    = {lo[H-2:0], 1'b0};
    out_lo   = lo[H-1];
    case (op)
      OP_LSR: begin
        sh_full = {1'b0, a[WIDTH-1:1]};       out_full = a[0];
        sh_lo   = {1'b0, lo[H-1:1]};          out_lo   = lo[0];
      end
      OP_ASR: begin
        sh_full = {a[WIDTH-1], a[WIDTH-1:1]}; out_full = a[0];
        sh_lo   = {lo[H-1], lo[H-1:1]};       out_lo   = lo[0];
      end
      OP_CSL: begin
        sh_full = {a[WIDTH-2:0], a[WIDTH-1]}; out_full = a[WIDTH-1];
        sh_lo   = {lo[H-2:0], lo[H-1]};       out_lo   = lo[H-1];
      end
      OP_CSR: begin
        sh_full = {a[0], a[WIDTH-1:1]};       out_full = a[0];
        sh_lo   = {lo[0], lo[H-1:1]};         out_lo   = lo[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    res  = a;
    cout = cin;
    ovf  = 1'b0;
    case (op)
      OP_PASS_A: res = a;
      OP_PASS_B: res = b;
      OP_NOT_A:  res = ~a;
      OP_NOT_B:  res = ~b;
      OP_ADD, OP_ADC, OP_SUB: begin
        res  = sum[WIDTH-1:0];
        // carry into bit H is the carry out of the low half
        cout = half ? (sum[H] ^ a[H] ^ add_b[H]) : sum[WIDTH];
        ovf  = (sa == sb) && (sr != sa);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NAND: res = ~(a & b);
      default: begin
        res  = half ? {{H{sh_lo[H-1]}}, sh_lo} : sh_full;
        cout = half ? out_lo : out_full;
      end
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops, bit-serial shifts, optional
// shift-add multiply enabled by SEQ_ALU_MUL_EN.
//   state  | meaning
//   S_IDLE | waiting for Start, operands latched on accept
//   S_EXEC | computing; one step per cycle for shifts/multiply
//   S_DONE | result and flags just updated, Done pulse
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       FunSel,
  input  logic [SHW-1:0]   ShAmt,
  input  logic             WF,
`ifdef SEQ_ALU_MUL_EN
  input  logic             Mul,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ALUOut,
  output logic [3:0]       FlagsOut
);

  localparam int H  = WIDTH / 2;
  localparam int CW = (SHW > $clog2(WIDTH)) ? SHW : $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [3:0]       op_r;
  logic             half_r, wf_r, c_run;
  logic [WIDTH-1:0] work, opb;
  logic [CW-1:0]    cnt;
  logic             is_mul, iter, do_step, last, accept;
  logic [3:0]       step_op;
  logic             step_half;
  logic [WIDTH-1:0] step_b, step_res, fin_val;
  logic             step_cout, step_ovf, fin_c, act_half, z_act, n_act;
  logic [3:0]       flags_nxt;

`ifdef SEQ_ALU_MUL_EN
  logic         mul_r;
  logic [H-1:0] mplier;
  assign is_mul = mul_r;
`else
  assign is_mul = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] sext_half(input logic [H-1:0] x);
    return {{H{x[H-1]}}, x};
  endfunction

  assign accept  = (state == S_IDLE) && Start;
  assign iter    = is_mul || is_shift_op(op_r);
  assign do_step = !iter || (cnt != '0);
  assign last    = !iter || (cnt <= CW'(1));
  assign Busy    = (state == S_EXEC);
  assign Done    = (state == S_DONE);

  always_comb begin
    step_op   = op_r;
    step_half = half_r;
    step_b    = opb;
`ifdef SEQ_ALU_MUL_EN
    if (mul_r) begin
      step_op   = OP_ADD;
      step_half = 1'b0;
      step_b    = mplier[0] ? opb : '0;
    end
`endif
  end

  seq_alu_step #(.WIDTH(WIDTH)) u_step (
    .op   (step_op),
    .half (step_half),
    .a    (work),
    .b    (step_b),
    .cin  (c_run),
    .res  (step_res),
    .cout (step_cout),
    .ovf  (step_ovf)
  );

  always_comb begin
    fin_val   = do_step ? step_res : work;
    fin_c     = do_step ? step_cout : c_run;
    act_half  = half_r && !is_mul;
    z_act     = act_half ? (fin_val[H-1:0] == '0) : (fin_val == '0);
    n_act     = act_half ? fin_val[H-1] : fin_val[WIDTH-1];
    flags_nxt = FlagsOut;
    if (wf_r) begin
      flags_nxt[FLAG_Z] = z_act;
      if (is_mul) begin
        flags_nxt[FLAG_N] = n_act;
        flags_nxt[FLAG_C] = 1'b0;
        flags_nxt[FLAG_O] = 1'b0;
      end else begin
        if (op_r != OP_ASR) flags_nxt[FLAG_N] = n_act;
        if (is_arith_op(op_r) || is_shift_op(op_r)) flags_nxt[FLAG_C] = fin_c;
        if (is_arith_op(op_r)) flags_nxt[FLAG_O] = step_ovf;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (Start) state_nxt = S_EXEC;
      S_EXEC:  if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      op_r     <= '0;
      half_r   <= 1'b0;
      wf_r     <= 1'b0;
      c_run    <= 1'b0;
      work     <= '0;
      opb      <= '0;
      cnt      <= '0;
      ALUOut   <= '0;
      FlagsOut <= '0;
`ifdef SEQ_ALU_MUL_EN
      mul_r    <= 1'b0;
      mplier   <= '0;
`endif
    end else if (accept) begin
      op_r   <= FunSel[3:0];
      half_r <= ~FunSel[4];
      wf_r   <= WF;
      c_run  <= FlagsOut[FLAG_C];
      work   <= FunSel[4] ? A : sext_half(A[H-1:0]);
      opb    <= FunSel[4] ? B : sext_half(B[H-1:0]);
      cnt    <= CW'(ShAmt);
`ifdef SEQ_ALU_MUL_EN
      mul_r  <= Mul;
      mplier <= B[H-1:0];
      if (Mul) begin
        work <= '0;
        opb  <= {{H{1'b0}}, A[H-1:0]};
        cnt  <= CW'(H);
      end
`endif
    end else if (state == S_EXEC) begin
      if (do_step) begin
        work  <= step_res;
        c_run <= step_cout;
      end
      if (iter && (cnt != '0)) cnt <= cnt - CW'(1);
`ifdef SEQ_ALU_MUL_EN
      if (mul_r) begin
        opb    <= opb << 1;
        mplier <= mplier >> 1;
      end
`endif
      if (last) begin
        ALUOut   <= fin_val;
        FlagsOut <= flags_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32) with a behavioural model and an expectation queue.
module tb_seq_alu;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [31:0] A, B;
  logic [4:0]  FunSel;
  logic [4:0]  ShAmt;
  logic        WF;
`ifdef SEQ_ALU_MUL_EN
  logic        mul;
`endif
  logic        Busy, Done;
  logic [31:0] ALUOut;
  logic [3:0]  FlagsOut;

  seq_alu #(.WIDTH(32)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .A        (A),
    .B        (B),
    .FunSel   (FunSel),
    .ShAmt    (ShAmt),
    .WF       (WF),
`ifdef SEQ_ALU_MUL_EN
    .Mul      (mul),
`endif
    .Busy     (Busy),
    .Done     (Done),
    .ALUOut   (ALUOut),
    .FlagsOut (FlagsOut)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    int          cyc;
  } exp_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  logic [3:0] mflags   = 4'b0000;

  // Reference model: flags are {Z,C,N,O}, evaluated at the active width.
  function automatic exp_t model(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                                 input int sh, input bit wf, input bit m, input logic [3:0] fl);
    exp_t        e;
    logic [31:0] x, y, r;
    int          w;
    longint      mask, v, ci, sa, sb2, sr, maxv, minv;
    bit          c, o, cu, ou, nu, sub, outb, z, n;
    w    = fs[4] ? 32 : 16;
    x    = fs[4] ? a : {{16{a[15]}}, a[15:0]};
    y    = fs[4] ? b : {{16{b[15]}}, b[15:0]};
    c    = fl[2]; o = fl[0]; cu = 0; ou = 0; nu = 1; outb = 0;
    e.cyc = 1;
    r    = x;
    if (m) begin
      w = 32;
      r = 32'(a[15:0]) * 32'(b[15:0]);
      c = 0; o = 0; cu = 1; ou = 1; e.cyc = 16;
    end else begin
      mask = (longint'(1) << w) - 1;
      case (fs[3:0])
        4'd0: r = x;
        4'd1: r = y;
        4'd2: r = ~x;
        4'd3: r = ~y;
        4'd4, 4'd5, 4'd6: begin
          sub = (fs[3:0] == 4'd6);
          ci  = (fs[3:0] == 4'd4) ? 0 : (fs[3:0] == 4'd5) ? longint'(fl[2]) : 1;
          r   = sub ? (x - y) : (x + y + 32'(ci));
          v   = (longint'(x) & mask) + (longint'(sub ? ~y : y) & mask) + ci;
          c   = ((v >> w) & 1) != 0;
          sa  = (w == 32) ? longint'($signed(x)) : longint'($signed(x[15:0]));
          sb2 = (w == 32) ? longint'($signed(y)) : longint'($signed(y[15:0]));
          sr  = sub ? (sa - sb2) : (sa + sb2 + ci);
          maxv = (longint'(1) << (w - 1)) - 1;
          minv = -(longint'(1) << (w - 1));
          o   = (sr > maxv) || (sr < minv);
          cu = 1; ou = 1;
        end
        4'd7:  r = x & y;
        4'd8:  r = x | y;
        4'd9:  r = x ^ y;
        4'd10: r = ~(x & y);
        default: begin
          v = longint'(x) & mask;
          for (int i = 0; i < sh; i++) begin
            case (fs[3:0])
              4'd11: begin outb = v[w-1]; v = (v << 1) & mask; end
              4'd12: begin outb = v[0];   v = v >> 1; end
              4'd13: begin outb = v[0];   v = (v >> 1) | (longint'(v[w-1]) << (w - 1)); end
              4'd14: begin outb = v[w-1]; v = ((v << 1) & mask) | longint'(outb); end
              default: begin outb = v[0]; v = (v >> 1) | (longint'(outb) << (w - 1)); end
            endcase
          end
          if (sh > 0) c = outb;
          r = (w == 32) ? v[31:0] : {{16{v[15]}}, v[15:0]};
          cu = 1;
          nu = (fs[3:0] != 4'd13);
          e.cyc = (sh == 0) ? 1 : sh;
        end
      endcase
    end
    z = (w == 32) ? (r == 32'd0) : (r[15:0] == 16'd0);
    n = r[w-1];
    e.res   = r;
    e.flags = fl;
    if (wf) begin
      e.flags[3] = z;
      if (cu) e.flags[2] = c;
      if (nu) e.flags[1] = n;
      if (ou) e.flags[0] = o;
    end
    return e;
  endfunction

  task automatic start_op(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input bit wf, input bit m);
    @(negedge Clock);
    FunSel = fs; A = a; B = b; ShAmt = sh; WF = wf;
`ifdef SEQ_ALU_MUL_EN
    mul = m;
`endif
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic issue_model(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] sh, input bit wf, input bit m);
    exp_t e;
    e = model(fs, a, b, int'(sh), wf, m, mflags);
    mflags = e.flags;
    sb.push_back(e);
    start_op(fs, a, b, sh, wf, m);
  endtask

  task automatic issue_const(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] sh, input bit m, input logic [31:0] res,
                             input logic [3:0] fl, input int cyc);
    exp_t e;
    e.res = res; e.flags = fl; e.cyc = cyc;
    mflags = fl;
    sb.push_back(e);
    start_op(fs, a, b, sh, 1'b1, m);
  endtask

  // Counts EXEC cycles until Done; returns at the sample where Done is high.
  task automatic wait_done(output int bc, output bit to);
    int n;
    bc = 0; n = 0;
    while (!Done && n < 200) begin
      if (Busy) bc++;
      @(negedge Clock);
      n++;
    end
    to = !Done;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; A = '0; B = '0; FunSel = '0; ShAmt = '0; WF = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    mul = 1'b0;
`endif
    #2 Reset = 1'b0;
    #2;
    checks++; if (ALUOut !== 32'd0) begin failures++; $display("FAIL rst_aluout: got %h want 0", ALUOut); end
    checks++; if (FlagsOut !== 4'b0000) begin failures++; $display("FAIL rst_flags: got %b want 0000", FlagsOut); end
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b want 0", Done); end
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    mflags = 4'b0000;
  endtask

  task automatic test_spec_vectors();
    logic [4:0]  fs[4];
    logic [31:0] va[4], vb[4], vr[4];
    logic [4:0]  vs[4];
    logic [3:0]  vf[4];
    int          vc[4];
    int          bc;
    bit          to;
    exp_t        e;
    fs[0] = 5'b10100; va[0] = 32'hFFFF_FFFF; vb[0] = 32'd1;          vs[0] = 5'd0;
    vr[0] = 32'h0000_0000; vf[0] = 4'b1100; vc[0] = 1;
    fs[1] = 5'b00110; va[1] = 32'h0000_7FFF; vb[1] = 32'h0000_FFFF; vs[1] = 5'd0;
    vr[1] = 32'h0000_8000; vf[1] = 4'b0011; vc[1] = 1;
    fs[2] = 5'b11011; va[2] = 32'h8000_0001; vb[2] = 32'd0;          vs[2] = 5'd3;
    vr[2] = 32'h0000_0008; vf[2] = 4'b0001; vc[2] = 3;
    fs[3] = 5'b11011; va[3] = 32'h8000_0001; vb[3] = 32'd0;          vs[3] = 5'd1;
    vr[3] = 32'h0000_0002; vf[3] = 4'b0101; vc[3] = 1;
    for (int i = 0; i < 4; i++) begin
      issue_const(fs[i], va[i], vb[i], vs[i], 1'b0, vr[i], vf[i], vc[i]);
      wait_done(bc, to);
      checks++; if (to) begin failures++; $display("FAIL vec%0d_timeout: Done=%b want 1", i, Done); end
      e = sb.pop_front();
      checks++; if (ALUOut !== e.res) begin failures++; $display("FAIL vec%0d_res: got %h want %h", i, ALUOut, e.res); end
      checks++; if (FlagsOut !== e.flags) begin failures++; $display("FAIL vec%0d_flags: got %b want %b", i, FlagsOut, e.flags); end
      checks++; if (bc !== e.cyc) begin failures++; $display("FAIL vec%0d_busy: got %0d want %0d", i, bc, e.cyc); end
    end
  endtask

  task automatic test_start_ignored();
    int   bc;
    bit   to;
    exp_t e;
    // Carry is 1 from the previous vector; rotate right by two.
    issue_const(5'b11111, 32'h0000_0002, 32'd0, 5'd2, 1'b0, 32'h8000_0000, 4'b0111, 2);
    FunSel = 5'b10000; A = 32'hFFFF_FFFF; ShAmt = 5'd7; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    wait_done(bc, to);
    checks++; if (to) begin failures++; $display("FAIL csr_timeout: Done=%b want 1", Done); end
    e = sb.pop_front();
    checks++; if (ALUOut !== e.res) begin failures++; $display("FAIL csr_res: got %h want %h", ALUOut, e.res); end
    checks++; if (FlagsOut !== e.flags) begin failures++; $display("FAIL csr_flags: got %b want %b", FlagsOut, e.flags); end
    checks++; if (bc + 1 !== e.cyc) begin failures++; $display("FAIL csr_busy: got %0d want %0d", bc + 1, e.cyc); end
    @(negedge Clock);
    checks++; if (Done !== 1'b0 || Busy !== 1'b0) begin
      failures++; $display("FAIL csr_after: Done=%b Busy=%b want 0 0", Done, Busy);
    end
  endtask

  task automatic test_reset_abort();
    bit   seen;
    int   bc;
    bit   to;
    exp_t e;
    start_op(5'b11011, 32'h0000_0001, 32'd0, 5'd5, 1'b1, 1'b0);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    checks++; if (ALUOut !== 32'd0) begin failures++; $display("FAIL abort_res: got %h want 0", ALUOut); end
    checks++; if (FlagsOut !== 4'b0000) begin failures++; $display("FAIL abort_flags: got %b want 0000", FlagsOut); end
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", Busy); end
    @(negedge Clock);
    Reset = 1'b1;
    mflags = 4'b0000;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      if (Done) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_done: got %b want 0", seen); end
    issue_model(5'b10101, 32'd5, 32'd7, 5'd0, 1'b1, 1'b0);
    wait_done(bc, to);
    e = sb.pop_front();
    checks++; if (to || ALUOut !== e.res) begin failures++; $display("FAIL resume_res: got %h want %h", ALUOut, e.res); end
    checks++; if (FlagsOut !== e.flags) begin failures++; $display("FAIL resume_flags: got %b want %b", FlagsOut, e.flags); end
  endtask

  task automatic test_random_ops();
    logic [4:0]  fs;
    logic [31:0] a, b;
    logic [4:0]  sh;
    int          bc;
    bit          to;
    exp_t        e;
    for (int i = 0; i < 24; i++) begin
      fs = 5'($urandom_range(0, 31));
      if (fs[3:0] >= 4'd11) fs[4] = 1'b1;
      a  = $urandom;
      b  = $urandom;
      if (i % 4 == 1) a[15] = 1'b0;
      sh = 5'($urandom_range(0, 5));
      issue_model(fs, a, b, sh, (i % 3) != 0, 1'b0);
      wait_done(bc, to);
      e = sb.pop_front();
      checks++; if (to || ALUOut !== e.res) begin
        failures++; $display("FAIL rnd%0d_res fs=%b: got %h want %h", i, fs, ALUOut, e.res);
      end
      checks++; if (FlagsOut !== e.flags) begin
        failures++; $display("FAIL rnd%0d_flags fs=%b: got %b want %b", i, fs, FlagsOut, e.flags);
      end
      checks++; if (bc !== e.cyc) begin
        failures++; $display("FAIL rnd%0d_busy fs=%b: got %0d want %0d", i, fs, bc, e.cyc);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e1, e2, e;
    int   bc;
    bit   to;
    e1 = model(5'b10100, 32'h7FFF_FFFF, 32'd1, 0, 1'b1, 1'b0, mflags);
    e2 = model(5'b00110, 32'h0000_0003, 32'h0000_0005, 0, 1'b1, 1'b0, e1.flags);
    mflags = e2.flags;
    sb.push_back(e1);
    sb.push_back(e2);
    @(negedge Clock);
    FunSel = 5'b10100; A = 32'h7FFF_FFFF; B = 32'd1; ShAmt = 5'd0; WF = 1'b1;
`ifdef SEQ_ALU_MUL_EN
    mul = 1'b0;
`endif
    Start = 1'b1;
    @(negedge Clock);
    FunSel = 5'b00110; A = 32'h0000_0003; B = 32'h0000_0005;
    wait_done(bc, to);
    e = sb.pop_front();
    checks++; if (to || ALUOut !== e.res) begin failures++; $display("FAIL b2b0_res: got %h want %h", ALUOut, e.res); end
    checks++; if (FlagsOut !== e.flags) begin failures++; $display("FAIL b2b0_flags: got %b want %b", FlagsOut, e.flags); end
    @(negedge Clock);
    checks++; if (Done !== 1'b0) begin failures++; $display("FAIL b2b_pulse: Done=%b want 0", Done); end
    @(negedge Clock);
    Start = 1'b0;
    wait_done(bc, to);
    e = sb.pop_front();
    checks++; if (to || ALUOut !== e.res) begin failures++; $display("FAIL b2b1_res: got %h want %h", ALUOut, e.res); end
    checks++; if (FlagsOut !== e.flags) begin failures++; $display("FAIL b2b1_flags: got %b want %b", FlagsOut, e.flags); end
    checks++; if (bc !== e.cyc) begin failures++; $display("FAIL b2b1_busy: got %0d want %0d", bc, e.cyc); end
  endtask

`ifdef SEQ_ALU_MUL_EN
  task automatic test_mul();
    int   bc;
    bit   to;
    exp_t e;
    issue_const(5'b00110, 32'h0000_FFFF, 32'h0000_FFFF, 5'd0, 1'b1, 32'hFFFE_0001,
                {1'b0, 1'b0, 1'b1, 1'b0}, 16);
    wait_done(bc, to);
    e = sb.pop_front();
    checks++; if (to || ALUOut !== e.res) begin failures++; $display("FAIL mul0_res: got %h want %h", ALUOut, e.res); end
    checks++; if (FlagsOut !== e.flags) begin failures++; $display("FAIL mul0_flags: got %b want %b", FlagsOut, e.flags); end
    checks++; if (bc !== e.cyc) begin failures++; $display("FAIL mul0_busy: got %0d want %0d", bc, e.cyc); end
    issue_model(5'b11011, 32'hABCD_1234, 32'h5555_00F3, 5'd9, 1'b1, 1'b1);
    wait_done(bc, to);
    e = sb.pop_front();
    checks++; if (to || ALUOut !== e.res) begin failures++; $display("FAIL mul1_res: got %h want %h", ALUOut, e.res); end
    checks++; if (FlagsOut !== e.flags) begin failures++; $display("FAIL mul1_flags: got %b want %b", FlagsOut, e.flags); end
    mul = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_spec_vectors();
    test_start_ignored();
    test_reset_abort();
    test_random_ops();
    test_back_to_back();
`ifdef SEQ_ALU_MUL_EN
    test_mul();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
